// File: rtl/prog_mem_pkg.sv
// Shared types and defaults for the program memory and its byte-stream loader.
package prog_mem_pkg;

    localparam int ADDR_W_DEF    = 8;
    localparam int DATA_W_DEF    = 16;
    // Position of the word-count byte within a program image
    localparam int HDR_COUNT_POS = 0;

    typedef enum logic [2:0] {
        L_COUNT,
        L_HI,
        L_LO,
        L_WRITE,
        L_CKSUM,
        L_DONE,
        L_ERR
    } loader_state_t;

endpackage

// File: rtl/prog_mem_ram.sv
// Unified program/data RAM: one synchronous write port, asynchronous read, contents not reset.
module prog_mem_ram
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_mem_loader.sv
// Program image loader in front of the CPU program/data RAM; holds the CPU in reset until loaded.
// Define LOADER_CHECKSUM_EN to require a trailing checksum byte (byte sum of image + checksum == 0).
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_mw,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W-1:0] load_count
);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t IMG_END_ST = L_CKSUM;
    logic [7:0]        r_sum;
    logic              r_load_err;
`else
    localparam loader_state_t IMG_END_ST = L_DONE;
`endif
    localparam logic END_IS_DONE = (IMG_END_ST == L_DONE);

    loader_state_t     r_state;
    logic              r_ld_ready;
    logic              r_cpu_rst;
    logic              r_load_done;
    logic [ADDR_W-1:0] r_wptr;
    logic [7:0]        r_n;
    logic [7:0]        r_hi;
    logic [7:0]        r_lo;

    logic              w_xfer;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_xfer = ld_valid && r_ld_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= L_COUNT;
            r_ld_ready  <= 1'b0;
            r_cpu_rst   <= 1'b1;
            r_load_done <= 1'b0;
            r_wptr      <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= 8'h00;
            r_load_err  <= 1'b0;
`endif
        end else begin
`ifdef LOADER_CHECKSUM_EN
            if (w_xfer) begin
                r_sum <= r_sum + ld_data;
            end
`endif
            case (r_state)
                L_COUNT: begin
                    r_ld_ready <= 1'b1;
                    if (w_xfer) begin
                        if (ld_data == 8'h00) begin
                            r_state     <= IMG_END_ST;
                            r_ld_ready  <= !END_IS_DONE;
                            r_cpu_rst   <= !END_IS_DONE;
                            r_load_done <= END_IS_DONE;
                        end else begin
                            r_state <= L_HI;
                        end
                    end
                end
                L_HI: begin
                    r_ld_ready <= 1'b1;
                    if (w_xfer) begin
                        r_state <= L_LO;
                    end
                end
                L_LO: begin
                    r_ld_ready <= 1'b1;
                    if (w_xfer) begin
                        r_state    <= L_WRITE;
                        r_ld_ready <= 1'b0;
                    end
                end
                // The RAM write itself happens through the port mux below
                L_WRITE: begin
                    r_wptr <= r_wptr + 1'b1;
                    if ((r_wptr + 1'b1) == ADDR_W'(r_n)) begin
                        r_state     <= IMG_END_ST;
                        r_ld_ready  <= !END_IS_DONE;
                        r_cpu_rst   <= !END_IS_DONE;
                        r_load_done <= END_IS_DONE;
                    end else begin
                        r_state    <= L_HI;
                        r_ld_ready <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                L_CKSUM: begin
                    r_ld_ready <= 1'b1;
                    if (w_xfer) begin
                        r_ld_ready <= 1'b0;
                        if (8'(r_sum + ld_data) == 8'h00) begin
                            r_state     <= L_DONE;
                            r_cpu_rst   <= 1'b0;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state    <= L_ERR;
                            r_load_err <= 1'b1;
                        end
                    end
                end
                L_ERR: begin
                    r_ld_ready <= 1'b0;
                end
`endif
                L_DONE: begin
                    r_ld_ready <= 1'b0;
                end
                default: begin
                    r_state    <= L_COUNT;
                    r_ld_ready <= 1'b0;
                end
            endcase
        end
    end

    // Byte holding registers carry no control meaning, so they are left out of reset
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            case (r_state)
                L_COUNT: r_n  <= ld_data;
                L_HI:    r_hi <= ld_data;
                L_LO:    r_lo <= ld_data;
                default: ;
            endcase
        end
    end

    // Loader and CPU never write in the same state, so a plain mux suffices
    assign w_we    = (r_state == L_WRITE) || ((r_state == L_DONE) && cpu_mw);
    assign w_waddr = (r_state == L_WRITE) ? r_wptr : cpu_addr;
    assign w_wdata = (r_state == L_WRITE) ? {r_hi, r_lo} : cpu_wdata;

    prog_mem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (cpu_addr),
        .o_rdata (cpu_rdata)
    );

    assign ld_ready   = r_ld_ready;
    assign cpu_rst    = r_cpu_rst;
    assign load_done  = r_load_done;
    assign load_count = r_wptr;
`ifdef LOADER_CHECKSUM_EN
    assign load_err   = r_load_err;
`else
    assign load_err   = 1'b0;
`endif

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- 256x16 unified program/data memory for the accumulator CPU, with a byte-stream program loader in front of it.
- After reset, accepts a program image over a valid/ready byte interface and writes it from address 0 upwards.
- Holds the CPU in reset until the load completes, then serves CPU instruction/data reads and store writes.

Parameters:
- ADDR_W, 8, address width; memory depth = 2**ADDR_W words.
- DATA_W, 16, memory word width; must be 16, because the loader packs two bytes per word.

Ports:
- clk  input  1  system clock
- rst  input  1  reset: asynchronous, active-high
- ld_data  input  8  loader byte
- ld_valid  input  1  loader byte valid
- ld_ready  output  1  loader can accept a byte
- cpu_addr  input  ADDR_W  CPU memory address (driven by CPU mar)
- cpu_mw  input  1  CPU write strobe
- cpu_wdata  input  DATA_W  CPU store data (driven by CPU acc)
- cpu_rdata  output  DATA_W  read data to CPU (CPU memory_data)
- cpu_rst  output  1  active-high reset to CPU; released only after load
- load_done  output  1  image loaded, CPU running
- load_err  output  1  load failed (checksum build only)
- load_count  output  ADDR_W  number of words written by the loader

Behaviour:
- Reset values: ld_ready=0, cpu_rst=1, load_done=0, load_err=0, load_count=0, write pointer=0, state=L_COUNT.
- Memory array is not reset; contents survive rst.
- Image format: byte 0 = word count N (0..255). Then N words, each sent high byte then low byte, written to address 0..N-1.
- Byte transfer occurs on a clk edge with ld_valid && ld_ready. ld_valid may stay high across multiple transfers.
- ld_ready is registered. It is high in L_COUNT, L_HI, L_LO and L_CKSUM, except on the first cycle after reset. It is low in L_WRITE, L_DONE and L_ERR.
- State transitions:
  - L_COUNT: on transfer, latch N. If N=0, go to L_CKSUM (with macro) or L_DONE (without); otherwise go to L_HI.
  - L_HI: on transfer, latch high byte; go to L_LO.
  - L_LO: on transfer, latch low byte; go to L_WRITE.
  - L_WRITE: one cycle. mem[wptr] <= {hi,lo}; wptr++; load_count++. If wptr+1==N, go to L_CKSUM/L_DONE; else go to L_HI.
  - L_DONE: terminal until rst. load_done=1 and cpu_rst=0, both registered, asserted on the first cycle in L_DONE.
- Read path: cpu_rdata = mem[cpu_addr], combinational (asynchronous read), valid in every state.
- Write path: in L_DONE only, posedge clk with cpu_mw=1 writes cpu_wdata to mem[cpu_addr]. cpu_mw is ignored outside L_DONE; the CPU is in reset there.
- The loader write (L_WRITE) and a CPU write are mutually exclusive by state, so no arbitration is needed.
- Bytes presented while in L_DONE/L_ERR are not accepted (ld_ready=0) and are dropped by the source's own rules.
- rst mid-load: return to L_COUNT, cpu_rst=1, load_count=0. Words already written remain in memory; a reload overwrites them.
- Wrap: wptr is ADDR_W bits, but N ≤ 255, so it never wraps.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- With macro:
  - An 8-bit running sum (mod 256) covers every accepted byte, including the count byte.
  - After the last word, state L_CKSUM accepts one checksum byte.
  - If sum + checksum == 8'h00, go to L_DONE.
  - Otherwise go to L_ERR: load_err=1, cpu_rst stays 1, ld_ready=0, held until rst.
- Without macro: no L_CKSUM/L_ERR states, no sum register, load_err tied 0.

Decomposition:
- Package prog_mem_pkg: loader state enum (L_COUNT, L_HI, L_LO, L_WRITE, L_CKSUM, L_DONE, L_ERR), ADDR_W/DATA_W defaults, image header constant (count byte position = 0).
- One natural sub-module: prog_mem_ram, a 2**ADDR_W x DATA_W single-write-port array with asynchronous read. The loader FSM muxes its write port between loader and CPU.

Test Plan:
- Load N=2, words 16'h0205, 16'h0306 (bytes 02 02 05 03 06) → mem[0]=0205, mem[1]=0306, load_count=2, cpu_rst falls on the cycle after the last L_WRITE, load_done=1.
- N=0 (no macro) → L_DONE immediately after count byte, cpu_rst=0, load_count=0, memory untouched.
- After load, cpu_addr=8'h06, cpu_mw=1, cpu_wdata=16'h00AB for one cycle → cpu_rdata at addr 06 reads 00AB next cycle. Same pulse during load (before done) → no write.
- ld_valid toggled randomly with gaps, N=3 → identical memory contents to back-to-back streaming. ld_ready is low in every L_WRITE cycle.
- rst asserted after the high byte of word 1 → load_count=0, cpu_rst=1, ld_ready returns after reset. A fresh image N=1 (16'hBEEF) loads with mem[0]=BEEF.
- LOADER_CHECKSUM_EN, N=1, word 16'h1234: checksum 8'hB9 (01+12+34+B9=0x100) → load_done=1. Checksum 8'h00 → load_err=1, cpu_rst stays 1.
